// File: rtl/seq_step_ctrl_pkg.sv
// Shared constants for the step controller: face codes, face values,
// controller state encoding and the code-to-face decode helper.
package seq_step_ctrl_pkg;

    // Face codes carried on state_q[3:1]
    localparam logic [2:0] CODE_A = 3'b101;
    localparam logic [2:0] CODE_B = 3'b100;
    localparam logic [2:0] CODE_C = 3'b011;
    localparam logic [2:0] CODE_D = 3'b110;
    localparam logic [2:0] CODE_E = 3'b111;
    localparam logic [2:0] CODE_F = 3'b010;

    // Face values presented on the face output
    localparam logic [2:0] FACE_ABC = 3'd3;
    localparam logic [2:0] FACE_D   = 3'd5;
    localparam logic [2:0] FACE_E   = 3'd6;
    localparam logic [2:0] FACE_F   = 3'd2;
    localparam logic [2:0] FACE_BAD = 3'd0;

    // Power-up / reset contents of state_q: face A, flag clear
    localparam logic [3:0] STATE_RST = {CODE_A, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK      = 2'd1,
        S_WAIT_REL = 2'd2,
        S_RUN      = 2'd3
    } fsm_e;

    // Codes 000/001 are not faces and decode to 0
    function automatic logic [2:0] face_of(input logic [2:0] code);
        logic [2:0] f;
        case (code)
            CODE_A, CODE_B, CODE_C: f = FACE_ABC;
            CODE_D:                 f = FACE_D;
            CODE_E:                 f = FACE_E;
            CODE_F:                 f = FACE_F;
            default:                f = FACE_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/face_successor.sv
// Combinational next-face lookup. Up order A>B>C>D>E>F>A, down is the
// reverse; any non-face code (top two bits 00) recovers to A.
module face_successor
    import seq_step_ctrl_pkg::*;
(
    input  logic [2:0] code_i,
    input  logic       dir_down_i,
    output logic [2:0] next_code_o
);

    // Successor table with recovery of illegal codes to A
    always_comb begin
        next_code_o = CODE_A;
        if (code_i[2:1] != 2'b00) begin
            if (dir_down_i) begin
                case (code_i)
                    CODE_A:  next_code_o = CODE_F;
                    CODE_B:  next_code_o = CODE_A;
                    CODE_C:  next_code_o = CODE_B;
                    CODE_D:  next_code_o = CODE_C;
                    CODE_E:  next_code_o = CODE_D;
                    CODE_F:  next_code_o = CODE_E;
                    default: next_code_o = CODE_A;
                endcase
            end else begin
                case (code_i)
                    CODE_A:  next_code_o = CODE_B;
                    CODE_B:  next_code_o = CODE_C;
                    CODE_C:  next_code_o = CODE_D;
                    CODE_D:  next_code_o = CODE_E;
                    CODE_E:  next_code_o = CODE_F;
                    CODE_F:  next_code_o = CODE_A;
                    default: next_code_o = CODE_A;
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_step_ctrl.sv
// Step controller: advances a face code either by a manual req/ack
// handshake (one advance per held request) or by an auto-run prescaler.
// Every output except the face decode is a register.
module seq_step_ctrl
    import seq_step_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_req,
    input  logic       dir_down,
    input  logic       auto_en,
    input  logic [3:0] rate,
    input  logic       flag_in,
    output logic [3:0] state_q,
    output logic [2:0] face,
    output logic       step_ack,
    output logic       step_strobe,
    output logic [3:0] lap,
    output logic       busy
);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] presc_q, presc_d;
    logic       adv;
    logic       manual;
    logic       wrap;
    logic [2:0] next_code;

    face_successor u_succ (
        .code_i      (state_q[3:1]),
        .dir_down_i  (dir_down),
        .next_code_o (next_code)
    );

    // Next-state, prescaler and advance decision; auto_en beats step_req
    always_comb begin
        fsm_d   = fsm_q;
        presc_d = presc_q;
        adv     = 1'b0;
        manual  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (auto_en) begin
                    fsm_d   = S_RUN;
                    presc_d = 4'd0;
                end else if (step_req) begin
                    fsm_d  = S_ACK;
                    adv    = 1'b1;
                    manual = 1'b1;
                end
            end
            S_ACK: fsm_d = S_WAIT_REL;
            S_WAIT_REL: begin
                if (auto_en) begin
                    fsm_d   = S_RUN;
                    presc_d = 4'd0;
                end else if (!step_req) begin
                    fsm_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!auto_en) begin
                    fsm_d = S_IDLE;
                end else if (presc_q >= rate) begin
                    // >= rather than == so a rate drop below the count fires at once
                    presc_d = 4'd0;
                    adv     = 1'b1;
                end else begin
                    presc_d = presc_q + 4'd1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // A lap completes when the sequence crosses the F/A boundary
    always_comb begin
        wrap = (!dir_down && state_q[3:1] == CODE_F) ||
               ( dir_down && state_q[3:1] == CODE_A);
    end

    // Registered state, pulses and lap counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            presc_q     <= 4'd0;
            state_q     <= STATE_RST;
            step_ack    <= 1'b0;
            step_strobe <= 1'b0;
            lap         <= 4'd0;
            busy        <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            presc_q     <= presc_d;
            step_ack    <= manual;
            step_strobe <= adv;
            busy        <= (fsm_d == S_RUN);
            if (adv) begin
                state_q <= {next_code, flag_in};
                if (wrap) lap <= lap + 4'd1;
            end
        end
    end

    // Zero-latency decode of the registered code
    always_comb begin
        face = face_of(state_q[3:1]);
    end

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Self-checking bench for seq_step_ctrl: successor/face tables, directed
// handshake and auto-run sequences, and randomized cycles against a model.
module tb_seq_step_ctrl;
    import seq_step_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_req = 1'b0;
    logic       dir_down = 1'b0;
    logic       auto_en = 1'b0;
    logic [3:0] rate = 4'd0;
    logic       flag_in = 1'b0;
    logic [3:0] state_q;
    logic [2:0] face;
    logic       step_ack;
    logic       step_strobe;
    logic [3:0] lap;
    logic       busy;

    logic [2:0] sc_code;
    logic       sc_dir;
    logic [2:0] sc_next;

    int tests = 0;
    int fails = 0;
    int n_stb = 0;
    int n_ack = 0;

    // Reference model: position in the up-order ring plus handshake/run bookkeeping
    logic [2:0] ORDER [6];
    logic [2:0] FACEV [6];
    int m_pos, m_lap, m_cnt, m_hs;
    bit m_flag, m_run, m_ack, m_stb;

    always #5 clk = ~clk;

    seq_step_ctrl dut (
        .clk(clk), .rst_n(rst_n), .step_req(step_req), .dir_down(dir_down),
        .auto_en(auto_en), .rate(rate), .flag_in(flag_in), .state_q(state_q),
        .face(face), .step_ack(step_ack), .step_strobe(step_strobe),
        .lap(lap), .busy(busy)
    );

    face_successor u_ref_succ (.code_i(sc_code), .dir_down_i(sc_dir), .next_code_o(sc_next));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit adv;
        adv = 0;
        m_ack = 0;
        if (!rst_n) begin
            m_pos = 0; m_flag = 0; m_lap = 0; m_run = 0; m_cnt = 0; m_hs = 0;
        end else if (m_run) begin
            if (!auto_en) m_run = 0;
            else if (m_cnt >= int'(rate)) begin m_cnt = 0; adv = 1; end
            else m_cnt++;
        end else if (m_hs == 1) begin
            m_hs = 2;
        end else if (m_hs == 2 && !auto_en) begin
            if (!step_req) m_hs = 0;
        end else begin
            if (auto_en) begin m_run = 1; m_cnt = 0; m_hs = 0; end
            else if (step_req) begin adv = 1; m_ack = 1; m_hs = 1; end
        end
        if (adv) begin
            if (!dir_down && m_pos == 5) m_lap = (m_lap + 1) % 16;
            if ( dir_down && m_pos == 0) m_lap = (m_lap + 1) % 16;
            m_pos = dir_down ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
            m_flag = flag_in;
        end
        m_stb = adv;
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("state", state_q, {ORDER[m_pos], m_flag});
        chk("face", face, FACEV[m_pos]);
        chk("ack", step_ack, m_ack);
        chk("strobe", step_strobe, m_stb);
        chk("lap", lap, m_lap);
        chk("busy", busy, m_run);
        if (step_strobe) n_stb++;
        if (step_ack) n_ack++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        chk("rst_state", state_q, 4'b1010);
        chk("rst_face", face, 3);
        chk("rst_lap", lap, 0);
        chk("rst_pulses", {step_ack, step_strobe, busy}, 3'b000);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] code;
        logic       dir;
        logic [2:0] nxt;
        logic [2:0] fval;
    } vec_t;

    initial begin
        vec_t vt [16];
        int faces_exp [6];
        ORDER = '{3'b101, 3'b100, 3'b011, 3'b110, 3'b111, 3'b010};
        FACEV = '{3'd3, 3'd3, 3'd3, 3'd5, 3'd6, 3'd2};
        faces_exp = '{3, 3, 5, 6, 2, 3};
        m_pos = 0; m_lap = 0; m_cnt = 0; m_hs = 0;
        m_flag = 0; m_run = 0; m_ack = 0; m_stb = 0;

        // Successor and face decode tables, both directions, all eight codes
        vt = '{
            '{3'b101, 1'b0, 3'b100, 3'd3}, '{3'b100, 1'b0, 3'b011, 3'd3},
            '{3'b011, 1'b0, 3'b110, 3'd3}, '{3'b110, 1'b0, 3'b111, 3'd5},
            '{3'b111, 1'b0, 3'b010, 3'd6}, '{3'b010, 1'b0, 3'b101, 3'd2},
            '{3'b000, 1'b0, 3'b101, 3'd0}, '{3'b001, 1'b0, 3'b101, 3'd0},
            '{3'b101, 1'b1, 3'b010, 3'd3}, '{3'b100, 1'b1, 3'b101, 3'd3},
            '{3'b011, 1'b1, 3'b100, 3'd3}, '{3'b110, 1'b1, 3'b011, 3'd5},
            '{3'b111, 1'b1, 3'b110, 3'd6}, '{3'b010, 1'b1, 3'b111, 3'd2},
            '{3'b000, 1'b1, 3'b101, 3'd0}, '{3'b001, 1'b1, 3'b101, 3'd0}
        };
        for (int i = 0; i < 16; i++) begin
            sc_code = vt[i].code;
            sc_dir  = vt[i].dir;
            #1;
            chk($sformatf("succ_%03b_%0d", vt[i].code, vt[i].dir), sc_next, vt[i].nxt);
            chk($sformatf("face_%03b", vt[i].code), face_of(vt[i].code), vt[i].fval);
        end

        // Reset state
        @(negedge clk);
        do_reset();

        // Six manual up steps walk A..F back to A, one lap
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            step_req = 1'b1;
            cyc();
            chk("up_strobe", step_strobe, 1);
            chk("up_face", face, faces_exp[i]);
            step_req = 1'b0;
            cyc();
            cyc();
        end
        chk("up_lap", lap, 1);
        chk("up_acks", n_ack, 6);

        // Single down step from A wraps to F
        do_reset();
        dir_down = 1'b1;
        flag_in = 1'b1;
        step_req = 1'b1;
        cyc();
        chk("dn_code", state_q, {3'b010, 1'b1});
        chk("dn_face", face, 2);
        chk("dn_lap", lap, 1);
        step_req = 1'b0;
        dir_down = 1'b0;
        flag_in = 1'b0;
        cyc();
        cyc();

        // Held request: exactly one advance and one ack
        n_stb = 0; n_ack = 0;
        step_req = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("held_stb", n_stb, 1);
        chk("held_ack", n_ack, 1);
        step_req = 1'b0;
        cyc();

        // Auto-run rate 3: a strobe every 4th cycle, step_req ignored
        rate = 4'd3;
        auto_en = 1'b1;
        cyc();
        n_stb = 0; n_ack = 0;
        for (int i = 0; i < 40; i++) begin
            step_req = 1'($urandom_range(0, 1));
            cyc();
            chk("run_stb_phase", step_strobe, (i % 4) == 3);
        end
        chk("run_stb", n_stb, 10);
        chk("run_ack", n_ack, 0);
        auto_en = 1'b0;
        step_req = 1'b0;
        cyc();
        chk("run_exit", {busy, step_strobe}, 2'b00);

        // Rate drop 15 -> 2 with the prescaler at 10
        do_reset();
        rate = 4'd15;
        auto_en = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) cyc();
        rate = 4'd2;
        cyc();
        chk("drop_first", step_strobe, 1);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("drop_phase", step_strobe, (i % 3) == 2);
        end

        // Reset mid-run
        rst_n = 1'b0;
        cyc();
        chk("midrun_rst", {state_q, face, lap, step_ack, step_strobe, busy},
            {4'b1010, 3'd3, 4'd0, 3'b000});
        rst_n = 1'b1;
        auto_en = 1'b0;

        // Reset in the ACK cycle aborts; a request held through reset restarts
        step_req = 1'b1;
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("midhs_rst", {state_q, step_ack, step_strobe}, {4'b1010, 2'b00});
        rst_n = 1'b1;
        cyc();
        chk("held_thru_rst", {step_ack, step_strobe}, 2'b11);
        step_req = 1'b0;
        cyc();
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 79) != 0);
            step_req = 1'($urandom_range(0, 1));
            dir_down = 1'($urandom_range(0, 1));
            flag_in  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 19) == 0) rate = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_step_ctrl.md
SEQ_STEP_CTRL -- requirements
Module: seq_step_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- step_req  in  1  manual step request, level, req/ack handshake.
- dir_down  in  1  step direction, 1 = down, 0 = up.
- auto_en  in  1  enables auto-run mode.
- rate  in  4  auto-run prescaler; one step every rate+1 cycles.
- flag_in  in  1  user flag, loaded into state_q[0] on every advance.
- state_q  out  4  registered state; bits[3:1] are the face code, bit[0] is the flag.
- face  out  3  decoded face value.
- step_ack  out  1  one-cycle acknowledge of a manual step.
- step_strobe  out  1  one-cycle pulse on every advance, manual or auto.
- lap  out  4  wrap counter, modulo 16.
- busy  out  1  high while in RUN.

Function
REQ-003 Face codes on state_q[3:1] SHALL be: A=101, B=100, C=011, D=110, E=111, F=010.
REQ-004 Face values SHALL be: A, B and C map to 3; D maps to 5; E maps to 6; F maps to 2.
REQ-005 Up order SHALL be A>B>C>D>E>F>A; down order SHALL be the exact reverse.
REQ-006 Any code with bits[2:1]=00 SHALL advance to A regardless of dir_down; face SHALL read 0 while such a code is held.
REQ-007 The controller FSM SHALL have four states: IDLE, ACK, WAIT_REL and RUN.
REQ-008 IDLE with auto_en=0 and step_req=1 SHALL advance state_q once, go to ACK and assert step_ack and step_strobe in the following cycle.
REQ-009 ACK SHALL last exactly one cycle and then go to WAIT_REL.
REQ-010 WAIT_REL SHALL return to IDLE only once step_req=0; a held step_req SHALL produce exactly one advance.
REQ-011 auto_en=1 in IDLE or WAIT_REL SHALL enter RUN and clear the prescaler; auto_en takes priority over step_req.
REQ-012 In RUN the prescaler SHALL increment each cycle; when prescaler >= rate it SHALL reload to 0 and advance state_q, pulsing step_strobe the next cycle.
REQ-013 With rate=0, RUN SHALL advance every cycle.
REQ-014 A rate change in RUN SHALL take effect at the next compare (>=); there SHALL be no lockup when the new rate is below the current count.
REQ-015 auto_en=0 in RUN SHALL go to IDLE without a further advance; step_req SHALL be ignored in RUN; step_ack SHALL never assert in RUN.
REQ-016 dir_down and flag_in SHALL be sampled in the advance cycle only.
REQ-017 lap SHALL increment, wrapping 15 to 0, on each advance F>A in the up direction or A>F in the down direction.
REQ-018 All outputs SHALL be registered; face SHALL be derived from state_q with zero-cycle combinational decode.

Reset
REQ-019 rst_n=0 at a clock edge SHALL force: FSM to IDLE, state_q=4'b1010 (A, flag 0), face=3, lap=0, prescaler=0, step_ack=0, step_strobe=0, busy=0.
REQ-020 Reset asserted mid-RUN or mid-handshake SHALL abort with no advance and no ack pulse.
REQ-021 After rst_n deasserts, a step_req still held high SHALL be treated as a new request.

Structure
REQ-022 A shared package SHALL hold: the face-code constants A to F, the face-value constants, and the FSM state enum.
REQ-023 The successor function SHALL be one combinational sub-module, face_successor, with inputs (code, dir_down) and output next code.
REQ-024 The target implementation size SHALL be 120 to 400 lines of RTL.

Verification
REQ-025 Reset, then 6 manual up steps (step_req pulses) -> face sequence 3,3,5,6,2,3; lap=1; six step_ack pulses.
REQ-026 From A, one manual down step -> state_q[3:1]=010, face=2, lap=1.
REQ-027 step_req held high for 20 cycles -> exactly one advance and one step_ack.
REQ-028 auto_en=1, rate=3 for 40 cycles -> step_strobe every 4 cycles, 10 advances, busy=1; step_req toggling has no effect.
REQ-029 Force code 000 by preload or backdoor, then step down -> next code is A (101).
REQ-030 rate changed from 15 to 2 with prescaler at 10 -> advance on the next cycle, then one advance every 3 cycles.
REQ-031 rst_n=0 mid-RUN -> all REQ-019 values hold the following cycle.
